unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port synchronous 4K-word memory (1-cycle read latency) between the instruction-fetch port and the data (load/store) port of the pipelined processor.
- Grants at most one access per cycle and returns read data to the correct requester one cycle later.
- Drives a stall to the fetch stage when fetch is refused.
- Has starvation protection so fetch cannot be locked out by back-to-back data traffic.

Parameters:
AW, 12, memory word-address width
DW, 32, data width
STARVE_LIMIT, 3, consecutive refused fetch cycles after which fetch wins the next conflict (1..15)
CW, 4, starvation counter width

Ports:
w_clk  in  1  clock, all state on rising edge
w_rst_n  in  1  asynchronous active-low reset
w_ce  in  1  clock enable; low freezes all state
w_i_req  in  1  fetch read request
w_i_addr  in  AW  fetch word address
w_i_gnt  out  1  fetch request accepted this cycle
w_i_rvalid  out  1  fetch read data valid
w_i_rdata  out  DW  fetch read data
w_d_req  in  1  data request; held stable until granted
w_d_we  in  1  1 = store, 0 = load
w_d_addr  in  AW  data word address
w_d_wdata  in  DW  store data
w_d_gnt  out  1  data request accepted this cycle
w_d_rvalid  out  1  load data valid
w_d_rdata  out  DW  load data
w_m_addr  out  AW  memory address
w_m_we  out  1  memory write enable
w_m_wdata  out  DW  memory write data
w_m_rdata  in  DW  memory read data, registered, valid the cycle after its address is presented
w_stall  out  1  w_i_req & ~w_i_gnt
w_stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
Reset (w_rst_n low, asynchronous):
- tag=NONE, starve_cnt=0, last_addr=0, w_stall_cnt=0.
- Grants, rvalids and w_m_we forced 0.
- Any in-flight read is discarded; no rvalid until a new read is granted after release.

Grant (combinational, gated by w_ce & w_rst_n):
- Only one requester → it is granted.
- Both request → data wins, unless starve_cnt >= STARVE_LIMIT, in which case fetch wins.
- w_ce low → no grants, w_m_we=0.

Memory drive:
- On a grant: w_m_addr = granted address, w_m_we = w_d_gnt & w_d_we, w_m_wdata = w_d_wdata.
- With no grant: w_m_addr = last_addr (registered copy of the last granted address) and w_m_we=0, so w_m_rdata stays stable.

Response tag FSM. States:
- NONE: no read outstanding.
- INSTR: fetch read outstanding.
- DATA: load outstanding.

Transitions on each enabled edge:
- i_gnt → INSTR.
- d_gnt & ~we → DATA.
- Otherwise (no grant, or store) → NONE.
- w_ce low → tag holds.

Response outputs:
- w_i_rvalid = (tag==INSTR) & w_ce.
- w_d_rvalid = (tag==DATA) & w_ce.
- Both rdata outputs = w_m_rdata (qualify with rvalid).
- Read latency is exactly 1 cycle. Throughput is 1 access per cycle; back-to-back grants are allowed with no bubble.

Starvation counter:
- On an enabled edge: +1 if w_i_req & ~w_i_gnt, saturating at STARVE_LIMIT.
- Cleared on w_i_gnt or ~w_i_req.
- Held while w_ce is low.

Stall counter:
- w_stall_cnt +1 per enabled edge with w_stall=1.
- Saturates at 32'hFFFFFFFF with no wrap.

Store followed by a load to the same address in the next cycle returns the new data (memory write-first on the next edge).

w_ce drop with a read outstanding:
- rvalid goes low while w_ce is low.
- The address is held, so data is unchanged.
- rvalid reasserts on the first cycle w_ce is high again.

Test Plan:
- Fetch-only stream to addresses 0,1,2,3 every cycle → w_i_gnt=1 each cycle; w_i_rvalid=1 from cycle 2 with the mem[0..3] contents in order; w_stall=0; w_stall_cnt=0.
- Simultaneous fetch@5 and load@9 with starve_cnt=0 → d_gnt=1, i_gnt=0, w_stall=1; next cycle w_d_rvalid=1 with mem[9], then fetch granted; w_stall_cnt=1.
- Data requests every cycle for 6 cycles while fetch requests continuously, STARVE_LIMIT=3 → fetch refused 3 cycles, granted on the 4th; starve_cnt returns to 0; data regranted the following cycle.
- Store 32'hDEADBEEF @12, then load @12 next cycle → w_m_we=1 for exactly one cycle; w_d_rvalid=1 with 32'hDEADBEEF; no w_i_rvalid or w_d_rvalid for the store itself.
- Fetch granted @7, w_ce low 2 cycles, then high → w_i_rvalid=0 during the low cycles; then w_i_rvalid=1 with mem[7]; w_m_addr=7 throughout.
- Load granted, w_rst_n pulsed low mid-cycle before the next edge → outputs clear immediately; no w_d_rvalid after release; w_stall_cnt=0; tag=NONE.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and memory bus of the unified memory arbiter.
// The arbiter takes the slave view; the processor/memory side takes the master view.
interface unified_mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          w_i_req;
  logic [AW-1:0] w_i_addr;
  logic          w_i_gnt;
  logic          w_i_rvalid;
  logic [DW-1:0] w_i_rdata;

  logic          w_d_req;
  logic          w_d_we;
  logic [AW-1:0] w_d_addr;
  logic [DW-1:0] w_d_wdata;
  logic          w_d_gnt;
  logic          w_d_rvalid;
  logic [DW-1:0] w_d_rdata;

  logic [AW-1:0] w_m_addr;
  logic          w_m_we;
  logic [DW-1:0] w_m_wdata;
  logic [DW-1:0] w_m_rdata;

  logic          w_stall;
  logic [31:0]   w_stall_cnt;

  modport slave (
    input  w_i_req, w_i_addr, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_m_rdata,
    output w_i_gnt, w_i_rvalid, w_i_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
    output w_m_addr, w_m_we, w_m_wdata, w_stall, w_stall_cnt
  );

  modport master (
    output w_i_req, w_i_addr, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_m_rdata,
    input  w_i_gnt, w_i_rvalid, w_i_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
    input  w_m_addr, w_m_we, w_m_wdata, w_stall, w_stall_cnt
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-port synchronous memory,
// steering 1-cycle-latency read data back to whichever port issued the read.
//
// state     | meaning
// TAG_NONE  | no read outstanding
// TAG_INSTR | fetch read outstanding
// TAG_DATA  | load outstanding
module unified_mem_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int CW           = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_ce,
  unified_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_INSTR = 2'd1,
    TAG_DATA  = 2'd2
  } tag_t;

  tag_t          tag_q;
  tag_t          tag_d;
  logic [CW-1:0] starve_q;
  logic [AW-1:0] last_addr_q;
  logic [31:0]   stall_cnt_q;

  logic en;
  logic fetch_priority;
  logic i_gnt;
  logic d_gnt;
  logic stall;

  assign en             = w_ce & w_rst_n;
  assign fetch_priority = (starve_q >= CW'(STARVE_LIMIT));
  assign i_gnt          = en & bus.w_i_req & (~bus.w_d_req | fetch_priority);
  assign d_gnt          = en & bus.w_d_req & ~i_gnt;
  assign stall          = bus.w_i_req & ~i_gnt;

  assign bus.w_i_gnt     = i_gnt;
  assign bus.w_d_gnt     = d_gnt;
  assign bus.w_stall     = stall;
  assign bus.w_stall_cnt = stall_cnt_q;

  // With no grant the last address is replayed so the registered read data stays put.
  assign bus.w_m_addr  = i_gnt ? bus.w_i_addr : (d_gnt ? bus.w_d_addr : last_addr_q);
  assign bus.w_m_we    = d_gnt & bus.w_d_we;
  assign bus.w_m_wdata = bus.w_d_wdata;

  assign bus.w_i_rdata = bus.w_m_rdata;
  assign bus.w_d_rdata = bus.w_m_rdata;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      tag_q <= TAG_NONE;
    end else if (w_ce) begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (i_gnt) begin
      tag_d = TAG_INSTR;
    end else if (d_gnt && !bus.w_d_we) begin
      tag_d = TAG_DATA;
    end
  end

  always_comb begin
    bus.w_i_rvalid = (tag_q == TAG_INSTR) & w_ce;
    bus.w_d_rvalid = (tag_q == TAG_DATA) & w_ce;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      starve_q    <= '0;
      last_addr_q <= '0;
      stall_cnt_q <= '0;
    end else if (w_ce) begin
      if (stall) begin
        starve_q <= fetch_priority ? CW'(STARVE_LIMIT) : starve_q + CW'(1);
      end else begin
        starve_q <= '0;
      end
      if (i_gnt || d_gnt) begin
        last_addr_q <= bus.w_m_addr;
      end
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus a random phase, all checked
// against a transaction-level model of grants, outstanding reads and counters.
module tb_unified_mem_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 3;

  logic w_clk = 1'b0;
  logic w_rst_n;
  logic w_ce;

  always #5 w_clk = ~w_clk;

  unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .CW(4)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_ce    (w_ce),
    .bus     (bus)
  );

  // Environment memory: single port, write-first, registered read.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge w_clk) begin
    if (bus.w_m_we === 1'b1) env_mem[bus.w_m_addr] = bus.w_m_wdata;
    bus.w_m_rdata <= env_mem[bus.w_m_addr];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            ref_pend;     // 0 none, 1 fetch read, 2 load
  logic [DW-1:0] ref_pdata;
  int            ref_starve;
  logic [AW-1:0] ref_last;
  logic [31:0]   ref_stall;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_pend   = 0;
    ref_starve = 0;
    ref_last   = '0;
    ref_stall  = '0;
  endtask

  // One clock cycle: drive, check combinational/registered outputs, advance model.
  task automatic cyc(input logic ireq, input logic [AW-1:0] iaddr, input logic dreq,
                     input logic dwe, input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata,
                     input logic ce, output logic dg_out);
    logic live, e_ig, e_dg, e_we, e_stall;
    logic [AW-1:0] e_addr;
    bus.w_i_req = ireq;  bus.w_i_addr = iaddr;
    bus.w_d_req = dreq;  bus.w_d_we = dwe;  bus.w_d_addr = daddr;  bus.w_d_wdata = dwdata;
    w_ce = ce;
    #1;
    live = ce && w_rst_n;
    e_ig = 1'b0;
    e_dg = 1'b0;
    if (live && ireq && dreq) begin
      if (ref_starve >= LIM) e_ig = 1'b1; else e_dg = 1'b1;
    end else if (live) begin
      e_ig = ireq;
      e_dg = dreq;
    end
    e_addr  = e_ig ? iaddr : (e_dg ? daddr : ref_last);
    e_we    = e_dg && dwe;
    e_stall = ireq && !e_ig;

    chk("i_gnt", 32'(bus.w_i_gnt), 32'(e_ig));
    chk("d_gnt", 32'(bus.w_d_gnt), 32'(e_dg));
    chk("m_addr", 32'(bus.w_m_addr), 32'(e_addr));
    chk("m_we", 32'(bus.w_m_we), 32'(e_we));
    if (e_we) chk("m_wdata", bus.w_m_wdata, dwdata);
    chk("stall", 32'(bus.w_stall), 32'(e_stall));
    chk("stall_cnt", bus.w_stall_cnt, ref_stall);
    chk("i_rvalid", 32'(bus.w_i_rvalid), 32'(ref_pend == 1 && ce));
    chk("d_rvalid", 32'(bus.w_d_rvalid), 32'(ref_pend == 2 && ce));
    if (ref_pend == 1 && ce) chk("i_rdata", bus.w_i_rdata, ref_pdata);
    if (ref_pend == 2 && ce) chk("d_rdata", bus.w_d_rdata, ref_pdata);

    @(posedge w_clk);
    if (live) begin
      if (e_we) ref_mem[daddr] = dwdata;
      if (e_ig) begin
        ref_pend  = 1;
        ref_pdata = ref_mem[iaddr];
      end else if (e_dg && !dwe) begin
        ref_pend  = 2;
        ref_pdata = ref_mem[daddr];
      end else begin
        ref_pend = 0;
      end
      if (e_stall) ref_starve = (ref_starve + 1 > LIM) ? LIM : ref_starve + 1;
      else         ref_starve = 0;
      if (e_stall && ref_stall != 32'hFFFF_FFFF) ref_stall = ref_stall + 32'd1;
      if (e_ig || e_dg) ref_last = e_addr;
    end
    dg_out = e_dg;
    @(negedge w_clk);
  endtask

  initial begin
    logic          dg;
    logic          d_pend;
    logic          rwe;
    logic [AW-1:0] rda;
    logic [DW-1:0] rwd;
    logic [AW-1:0] dad;

    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    w_rst_n = 1'b1;
    w_ce    = 1'b1;
    bus.w_i_req = 1'b0;  bus.w_i_addr = '0;
    bus.w_d_req = 1'b0;  bus.w_d_we = 1'b0;  bus.w_d_addr = '0;  bus.w_d_wdata = '0;
    model_reset();
    #2 w_rst_n = 1'b0;

    // Reset state
    @(negedge w_clk);
    #1;
    chk("rst_i_gnt", 32'(bus.w_i_gnt), 32'd0);
    chk("rst_d_rvalid", 32'(bus.w_d_rvalid), 32'd0);
    chk("rst_i_rvalid", 32'(bus.w_i_rvalid), 32'd0);
    chk("rst_m_we", 32'(bus.w_m_we), 32'd0);
    chk("rst_m_addr", 32'(bus.w_m_addr), 32'd0);
    chk("rst_stall_cnt", bus.w_stall_cnt, 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;

    // Fetch-only stream 0..3
    for (int a = 0; a < 4; a++) cyc(1'b1, AW'(a), 1'b0, 1'b0, '0, '0, 1'b1, dg);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dg);
    chk("fetch_stream_stall_cnt", bus.w_stall_cnt, 32'd0);

    // Conflict with no starvation: data wins, fetch next
    cyc(1'b1, 12'd5, 1'b1, 1'b0, 12'd9, '0, 1'b1, dg);
    cyc(1'b1, 12'd5, 1'b0, 1'b0, '0, '0, 1'b1, dg);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dg);
    chk("conflict_stall_cnt", bus.w_stall_cnt, 32'd1);

    // Continuous data traffic against continuous fetch: fetch wins every 4th cycle
    dad = 12'd20;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 12'd30, 1'b1, 1'b0, dad, '0, 1'b1, dg);
      if (k == 3) chk("starve_fetch_wins", 32'(dg), 32'd0);
      if (dg) dad = dad + 12'd1;
    end
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dg);

    // Store then load same address
    cyc(1'b0, '0, 1'b1, 1'b1, 12'd12, 32'hDEAD_BEEF, 1'b1, dg);
    cyc(1'b0, '0, 1'b1, 1'b0, 12'd12, '0, 1'b1, dg);
    #1;
    chk("store_load_data", bus.w_d_rdata, 32'hDEAD_BEEF);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dg);

    // Clock-enable drop with a fetch outstanding
    cyc(1'b1, 12'd7, 1'b0, 1'b0, '0, '0, 1'b1, dg);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, dg);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, dg);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dg);

    // Reset pulse mid-cycle with a load outstanding
    cyc(1'b0, '0, 1'b1, 1'b0, 12'd40, '0, 1'b1, dg);
    bus.w_d_req = 1'b1;
    #2 w_rst_n = 1'b0;
    #1;
    chk("rst_pulse_d_rvalid", 32'(bus.w_d_rvalid), 32'd0);
    chk("rst_pulse_d_gnt", 32'(bus.w_d_gnt), 32'd0);
    chk("rst_pulse_stall_cnt", bus.w_stall_cnt, 32'd0);
    chk("rst_pulse_m_addr", 32'(bus.w_m_addr), 32'd0);
    model_reset();
    bus.w_d_req = 1'b0;
    #1 w_rst_n = 1'b1;
    @(negedge w_clk);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dg);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, dg);

    // Random traffic; a data request is held until the model says it was granted
    d_pend = 1'b0;
    rwe    = 1'b0;
    rda    = '0;
    rwd    = '0;
    for (int n = 0; n < 400; n++) begin
      if (!d_pend && ($urandom_range(0, 2) != 0)) begin
        d_pend = 1'b1;
        rwe    = ($urandom_range(0, 1) == 1);
        rda    = AW'($urandom_range(0, 15));
        rwd    = $urandom;
      end
      cyc(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)), d_pend, rwe, rda, rwd,
          ($urandom_range(0, 7) != 0), dg);
      if (dg) d_pend = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
